// File: rtl/diff_scan_unit_if.sv
// Request/result handshake bundle for the differing-bit scan unit.
// The master drives operands and consumes results; the slave is the unit itself.
interface diff_scan_unit_if #(
  parameter int WIDTH = 32
);
  localparam int IDXW = $clog2(WIDTH);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [IDXW-1:0]  out;
  logic             eq;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, B, mode, in_valid, out_ready,
    input  in_ready, out, eq, out_valid
  );

  modport slave (
    input  A, B, mode, in_valid, out_ready,
    output in_ready, out, eq, out_valid
  );
endinterface

// File: rtl/diff_scan_unit.sv
// Finds the most- or least-significant bit where A and B differ,
// scanning one CHUNK-wide slice of A^B per clock.
module diff_scan_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic              clk,
  input logic              rst,
  diff_scan_unit_if.slave  bus
);
  localparam int IDXW = $clog2(WIDTH);
  localparam int NCH  = WIDTH / CHUNK;
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} stateT;

  stateT            state;
  logic [WIDTH-1:0] xReg;
  logic             modeReg;
  logic [CW-1:0]    cnt;
  logic [IDXW-1:0]  outReg;
  logic             eqReg;
  logic             inReadyReg;
  logic             outValidReg;

  int               chunkSel;
  int               bitPos;
  logic [CHUNK-1:0] chunkBits;
  logic [IDXW-1:0]  hitIdx;
  logic             lastChunk;

  // Scan-order counter maps to a physical chunk; the loop direction makes the
  // last set bit seen be the highest (mode 0) or the lowest (mode 1).
  always_comb begin
    chunkSel  = modeReg ? int'(cnt) : (NCH - 1 - int'(cnt));
    chunkBits = CHUNK'(xReg >> (chunkSel * CHUNK));
    bitPos    = 0;
    if (!modeReg) begin
      for (int i = 0; i < CHUNK; i++)
        if (chunkBits[i]) bitPos = i;
    end else begin
      for (int i = CHUNK - 1; i >= 0; i--)
        if (chunkBits[i]) bitPos = i;
    end
    hitIdx    = IDXW'(chunkSel * CHUNK + bitPos);
    lastChunk = (cnt == CW'(NCH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      xReg        <= '0;
      modeReg     <= 1'b0;
      cnt         <= '0;
      outReg      <= '0;
      eqReg       <= 1'b0;
      inReadyReg  <= 1'b1;
      outValidReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xReg       <= bus.A ^ bus.B;
            modeReg    <= bus.mode;
            cnt        <= '0;
            inReadyReg <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (chunkBits != '0) begin
            outReg      <= hitIdx;
            eqReg       <= 1'b0;
            outValidReg <= 1'b1;
            state       <= DONE;
          end else if (lastChunk) begin
            outReg      <= '0;
            eqReg       <= 1'b1;
            outValidReg <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = inReadyReg;
  assign bus.out_valid = outValidReg;
  assign bus.out       = outReg;
  assign bus.eq        = eqReg;
endmodule

// File: doc/diff_scan_unit.md
DIFF_SCAN_UNIT -- requirements
Module: diff_scan_unit

Interface
REQ-001 Parameter WIDTH, default 32, meaning operand width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 8, meaning bits examined per scan cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 Derived localparam IDXW = clog2(WIDTH) and NCH = WIDTH/CHUNK SHALL be computed internally, not exposed as overridable parameters.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 A  input  WIDTH  first operand.
REQ-007 B  input  WIDTH  second operand.
REQ-008 mode  input  1  0 = report most-significant differing bit, 1 = report least-significant differing bit.
REQ-009 in_valid  input  1  request present on A/B/mode.
REQ-010 in_ready  output  1  unit can accept a request.
REQ-011 out  output  IDXW  bit index of the selected differing bit.
REQ-012 eq  output  1  A equals B (no differing bit).
REQ-013 out_valid  output  1  out/eq hold a result.
REQ-014 out_ready  input  1  consumer takes the result.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, SCAN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur on a rising edge with state IDLE and in_valid=1; at accept the unit SHALL latch X = A ^ B and mode, clear the chunk counter and enter SCAN.
REQ-018 in_valid in SCAN or DONE SHALL be ignored without side effects.
REQ-019 Scan order: mode=0 SHALL examine chunks from bits [WIDTH-1 : WIDTH-CHUNK] downward; mode=1 SHALL examine chunks from bits [CHUNK-1 : 0] upward.
REQ-020 Each SCAN edge SHALL examine exactly one chunk.
REQ-021 If the examined chunk is nonzero, the unit SHALL load out with the absolute index of its highest set bit (mode=0) or lowest set bit (mode=1), clear eq and enter DONE.
REQ-022 If the examined chunk is zero and is not the last, the unit SHALL advance the counter and remain in SCAN.
REQ-023 If the last chunk (counter = NCH-1) is zero, the unit SHALL set eq=1 and out=0 and enter DONE.
REQ-024 Latency: when the hit is in scan-order chunk k (0-based), out_valid SHALL rise k+1 edges after the accept edge; equal operands SHALL take NCH edges.
REQ-025 In DONE, out and eq SHALL be held stable until the edge where out_ready=1; the unit SHALL then enter IDLE.
REQ-026 out_ready in IDLE or SCAN SHALL be ignored.
REQ-027 A new request SHALL be accepted no earlier than the edge after DONE exits; there is no back-to-back bypass.
REQ-028 A, B and mode changes after accept SHALL NOT affect the in-flight result.

Reset
REQ-029 When rst=0, the unit SHALL immediately and asynchronously force state=IDLE, counter=0, out=0, eq=0 and out_valid=0, so that in_ready=1, regardless of the current state, including mid-SCAN and in DONE.
REQ-030 An in-flight operation interrupted by reset SHALL be discarded, with no result produced after release.
REQ-031 The first accept SHALL be possible on the first rising edge with rst=1.

Verification (WIDTH=32, CHUNK=8)
REQ-032 A=126, B=2, mode=0 -> out=6, eq=0, out_valid 4 edges after accept; with mode=1 -> out=2, out_valid after 1 edge.
REQ-033 A=4, B=12, mode=0 and mode=1 -> out=3, eq=0; latency 4 edges (mode=0) and 1 edge (mode=1).
REQ-034 A=B=0xDEADBEEF, either mode -> eq=1, out=0, out_valid 4 edges after accept.
REQ-035 A=0x80000000, B=0, mode=0 -> out=31 after 1 edge; mode=1 -> out=31 after 4 edges.
REQ-036 Hold out_ready=0 for 3 cycles in DONE while toggling in_valid, A and B -> out/eq stable, in_ready=0, no new accept; then out_ready=1 -> IDLE on the next edge.
REQ-037 Drop rst mid-SCAN (A=1, B=0, mode=0, after 2 edges) -> outputs 0 and in_ready=1 without a clock edge; no out_valid after release until a new request is accepted.
